mac_top_wrap: RTL and testbench

MAC_TOP_WRAP -- requirements
Module: mac_top_wrap

---
 rtl/mac_top_wrap.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_mac_top_wrap.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_top_wrap.sv
// Register-programmed MAC engine: a/b/c read streams on TCDM ports 0-2, d written on port 3.
// Peripheral reply one cycle after accept; TCDM requests are held until granted, one read in flight per port.
module mac_top_wrap #(
    parameter int N_CORES = 2,
    parameter int MP      = 4,
    parameter int ID      = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_mode_i,
    output logic [MP-1:0]             tcdm_req,
    input  logic [MP-1:0]             tcdm_gnt,
    output logic [MP-1:0][31:0]       tcdm_add,
    output logic [MP-1:0]             tcdm_wen,
    output logic [MP-1:0][3:0]        tcdm_be,
    output logic [MP-1:0][31:0]       tcdm_data,
    input  logic [MP-1:0][31:0]       tcdm_r_data,
    input  logic [MP-1:0]             tcdm_r_valid,
    input  logic                      periph_req,
    output logic                      periph_gnt,
    input  logic [31:0]               periph_add,
    input  logic                      periph_wen,
    input  logic [3:0]                periph_be,
    input  logic [31:0]               periph_data,
    input  logic [ID-1:0]             periph_id,
    output logic [31:0]               periph_r_data,
    output logic                      periph_r_valid,
    output logic [ID-1:0]             periph_r_id,
    output logic [N_CORES-1:0][1:0]   evt_o
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_COMPUTE, S_STORE, S_DONE} state_e;

    state_e             state_q, state_d;
    logic [31:0]        a_addr_q, a_addr_d, b_addr_q, b_addr_d, c_addr_q, c_addr_d, d_addr_q, d_addr_d;
    logic [15:0]        nb_iter_q, nb_iter_d, len_q, len_d;
    logic [4:0]         shift_q, shift_d;
    logic               simple_q, simple_d;
    logic [3:0]         req_q, req_d;
    logic [2:0]         pend_q, pend_d;
    logic [3:0][31:0]   add_q, add_d;
    logic [2:0][31:0]   dat_q, dat_d;
    logic [31:0]        wdat_q, wdat_d;
    logic               fetch_q, fetch_d;
    logic signed [63:0] acc_q, acc_d;
    logic [31:0]        elem_q, elem_d;
    logic [15:0]        j_q, j_d, iter_q, iter_d;
    logic               r_valid_q, r_valid_d;
    logic [31:0]        r_data_q, r_data_d;
    logic [ID-1:0]      r_id_q, r_id_d;

    logic               accept, busy, launch, go_store;
    logic [7:0]         off;
    logic [31:0]        wmask, wdat_m, rd_val, store_idx;
    logic [63:0]        a_ext, b_ext;
    logic signed [63:0] prod, acc_sum, shifted;
    logic               unused_sink;

    assign unused_sink = ^{test_mode_i, periph_add[31:8], tcdm_r_data[3], tcdm_r_valid[3]};

    assign periph_gnt = ~rst_ni;
    assign accept     = periph_req & periph_gnt;
    assign busy       = (state_q != S_IDLE);
    assign off        = periph_add[7:0];
    assign wmask      = {{8{periph_be[3]}}, {8{periph_be[2]}}, {8{periph_be[1]}}, {8{periph_be[0]}}};
    assign wdat_m     = periph_data & wmask;

    // Sign-extend before multiplying so the low 64 bits are the exact signed product.
    assign a_ext      = {{32{dat_q[0][31]}}, dat_q[0]};
    assign b_ext      = {{32{dat_q[1][31]}}, dat_q[1]};
    assign prod       = $signed(a_ext) * $signed(b_ext);
    assign acc_sum    = acc_q + prod;
    assign shifted    = (simple_q ? prod : acc_sum) >>> shift_q;
    assign store_idx  = simple_q ? elem_q : {16'b0, iter_q};

    always_comb begin
        rd_val = 32'h0;
        case (off)
            8'h04:   rd_val = busy ? 32'hFFFF_FFFF : 32'h0;
            8'h0C:   rd_val = {31'b0, busy};
            8'h40:   rd_val = a_addr_q;
            8'h44:   rd_val = b_addr_q;
            8'h48:   rd_val = c_addr_q;
            8'h4C:   rd_val = d_addr_q;
            8'h50:   rd_val = {16'b0, nb_iter_q};
            8'h54:   rd_val = {16'b0, len_q};
            8'h58:   rd_val = {27'b0, shift_q};
            8'h5C:   rd_val = {31'b0, simple_q};
            default: rd_val = 32'h0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        a_addr_d  = a_addr_q;
        b_addr_d  = b_addr_q;
        c_addr_d  = c_addr_q;
        d_addr_d  = d_addr_q;
        nb_iter_d = nb_iter_q;
        len_d     = len_q;
        shift_d   = shift_q;
        simple_d  = simple_q;
        req_d     = req_q;
        pend_d    = pend_q;
        add_d     = add_q;
        dat_d     = dat_q;
        wdat_d    = wdat_q;
        fetch_d   = fetch_q;
        acc_d     = acc_q;
        elem_d    = elem_q;
        j_d       = j_q;
        iter_d    = iter_q;
        launch    = 1'b0;
        go_store  = 1'b0;
        r_valid_d = accept;
        r_id_d    = accept ? periph_id : '0;
        r_data_d  = (accept && periph_wen) ? rd_val : 32'h0;

        if (accept && !periph_wen && !busy) begin
            case (off)
                8'h00:   state_d   = (len_q != 16'h0 && nb_iter_q != 16'h0) ? S_START : S_DONE;
                8'h40:   a_addr_d  = (a_addr_q & ~wmask) | wdat_m;
                8'h44:   b_addr_d  = (b_addr_q & ~wmask) | wdat_m;
                8'h48:   c_addr_d  = (c_addr_q & ~wmask) | wdat_m;
                8'h4C:   d_addr_d  = (d_addr_q & ~wmask) | wdat_m;
                8'h50:   nb_iter_d = (nb_iter_q & ~wmask[15:0]) | wdat_m[15:0];
                8'h54:   len_d     = (len_q & ~wmask[15:0]) | wdat_m[15:0];
                8'h58:   shift_d   = (shift_q & ~wmask[4:0]) | wdat_m[4:0];
                8'h5C:   simple_d  = (simple_q & ~wmask[0]) | wdat_m[0];
                default: ;
            endcase
        end

        // Read ports: grant moves the request to pending; data is captured only while pending.
        for (int p = 0; p < 3; p++) begin
            if (req_q[p] && tcdm_gnt[p]) begin
                req_d[p]  = 1'b0;
                pend_d[p] = 1'b1;
            end
            if (pend_q[p] && tcdm_r_valid[p]) begin
                pend_d[p] = 1'b0;
                dat_d[p]  = tcdm_r_data[p];
            end
        end

        case (state_q)
            S_START: begin
                acc_d   = '0;
                elem_d  = 32'h0;
                j_d     = 16'h0;
                iter_d  = 16'h0;
                launch  = 1'b1;
                state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (fetch_q && req_q[2:0] == 3'b000 && pend_q == 3'b000) begin
                    fetch_d = 1'b0;
                    if (simple_q) begin
                        wdat_d   = shifted[31:0];
                        go_store = 1'b1;
                    end else begin
                        acc_d  = acc_sum;
                        elem_d = elem_q + 32'd1;
                        if (j_q + 16'd1 == len_q) begin
                            wdat_d   = dat_q[2] + shifted[31:0];
                            go_store = 1'b1;
                        end else begin
                            j_d    = j_q + 16'd1;
                            launch = 1'b1;
                        end
                    end
                end
            end
            S_STORE: begin
                if (tcdm_gnt[3]) begin
                    req_d[3] = 1'b0;
                    if (simple_q) begin
                        if (elem_q + 32'd1 == {16'b0, len_q}) begin
                            state_d = S_DONE;
                        end else begin
                            elem_d  = elem_q + 32'd1;
                            launch  = 1'b1;
                            state_d = S_COMPUTE;
                        end
                    end else begin
                        if (iter_q + 16'd1 == nb_iter_q) begin
                            state_d = S_DONE;
                        end else begin
                            iter_d  = iter_q + 16'd1;
                            j_d     = 16'h0;
                            acc_d   = '0;
                            launch  = 1'b1;
                            state_d = S_COMPUTE;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        if (go_store) begin
            state_d  = S_STORE;
            req_d[3] = 1'b1;
            add_d[3] = d_addr_q + {store_idx[29:0], 2'b00};
        end

        // c is fetched once per iteration, alongside its first a/b pair.
        if (launch) begin
            req_d[0] = 1'b1;
            req_d[1] = 1'b1;
            req_d[2] = !simple_q && (j_d == 16'h0);
            add_d[0] = a_addr_q + {elem_d[29:0], 2'b00};
            add_d[1] = b_addr_q + {elem_d[29:0], 2'b00};
            add_d[2] = c_addr_q + {14'b0, iter_d, 2'b00};
            fetch_d  = 1'b1;
        end

        if (accept && !periph_wen && off == 8'h14) begin
            state_d   = S_IDLE;
            a_addr_d  = 32'h0;
            b_addr_d  = 32'h0;
            c_addr_d  = 32'h0;
            d_addr_d  = 32'h0;
            nb_iter_d = 16'h0;
            len_d     = 16'h0;
            shift_d   = 5'h0;
            simple_d  = 1'b0;
            req_d     = '0;
            pend_d    = '0;
            add_d     = '0;
            dat_d     = '0;
            wdat_d    = 32'h0;
            fetch_d   = 1'b0;
            acc_d     = '0;
            elem_d    = 32'h0;
            j_d       = 16'h0;
            iter_d    = 16'h0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            state_q   <= S_IDLE;
            a_addr_q  <= 32'h0;
            b_addr_q  <= 32'h0;
            c_addr_q  <= 32'h0;
            d_addr_q  <= 32'h0;
            nb_iter_q <= 16'h0;
            len_q     <= 16'h0;
            shift_q   <= 5'h0;
            simple_q  <= 1'b0;
            req_q     <= '0;
            pend_q    <= '0;
            add_q     <= '0;
            dat_q     <= '0;
            wdat_q    <= 32'h0;
            fetch_q   <= 1'b0;
            acc_q     <= '0;
            elem_q    <= 32'h0;
            j_q       <= 16'h0;
            iter_q    <= 16'h0;
            r_valid_q <= 1'b0;
            r_data_q  <= 32'h0;
            r_id_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_addr_q  <= a_addr_d;
            b_addr_q  <= b_addr_d;
            c_addr_q  <= c_addr_d;
            d_addr_q  <= d_addr_d;
            nb_iter_q <= nb_iter_d;
            len_q     <= len_d;
            shift_q   <= shift_d;
            simple_q  <= simple_d;
            req_q     <= req_d;
            pend_q    <= pend_d;
            add_q     <= add_d;
            dat_q     <= dat_d;
            wdat_q    <= wdat_d;
            fetch_q   <= fetch_d;
            acc_q     <= acc_d;
            elem_q    <= elem_d;
            j_q       <= j_d;
            iter_q    <= iter_d;
            r_valid_q <= r_valid_d;
            r_data_q  <= r_data_d;
            r_id_q    <= r_id_d;
        end
    end

    assign periph_r_valid = r_valid_q;
    assign periph_r_data  = r_data_q;
    assign periph_r_id    = r_id_q;
    assign tcdm_req       = req_q;
    assign tcdm_wen       = {~req_q[3], 3'b111};

    always_comb begin
        for (int p = 0; p < 4; p++) begin
            tcdm_add[p]  = add_q[p];
            tcdm_be[p]   = req_q[p] ? 4'hF : 4'h0;
            tcdm_data[p] = (p == 3) ? wdat_q : 32'h0;
        end
        for (int k = 0; k < N_CORES; k++) begin
            evt_o[k] = {1'b0, state_q == S_DONE};
        end
    end
endmodule

// File: tb/tb_mac_top_wrap.sv
// Directed bench for mac_top_wrap: register file, simple and accumulate jobs, stalls, clear and reset aborts.
module tb_mac_top_wrap;
    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              test_mode_i;
    logic [3:0]        tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
    logic [3:0][31:0]  tcdm_add, tcdm_data, tcdm_r_data;
    logic [3:0][3:0]   tcdm_be;
    logic              periph_req, periph_gnt, periph_wen, periph_r_valid;
    logic [31:0]       periph_add, periph_data, periph_r_data;
    logic [3:0]        periph_be;
    logic [9:0]        periph_id, periph_r_id;
    logic [1:0][1:0]   evt_o;

    mac_top_wrap #(.N_CORES(2), .MP(4), .ID(10)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i),
        .tcdm_req(tcdm_req), .tcdm_gnt(tcdm_gnt), .tcdm_add(tcdm_add), .tcdm_wen(tcdm_wen),
        .tcdm_be(tcdm_be), .tcdm_data(tcdm_data), .tcdm_r_data(tcdm_r_data), .tcdm_r_valid(tcdm_r_valid),
        .periph_req(periph_req), .periph_gnt(periph_gnt), .periph_add(periph_add), .periph_wen(periph_wen),
        .periph_be(periph_be), .periph_data(periph_data), .periph_id(periph_id),
        .periph_r_data(periph_r_data), .periph_r_valid(periph_r_valid), .periph_r_id(periph_r_id),
        .evt_o(evt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_chk = 0, n_bad = 0;
    logic [31:0] mem [512];
    logic        stall = 1'b0;
    int          hs_cnt [4];
    int          wr_cnt = 0, stab_viol = 0, be_viol = 0;
    int          evt_cnt = 0, evt_bad = 0, req_cyc = 0;
    logic [9:0]  cur_id = 10'h155, exp_id;
    logic        last_rv;
    logic [9:0]  last_rid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic reg_acc(input logic wen, input logic [7:0] off, input logic [31:0] wdat,
                           input logic [3:0] be, output logic [31:0] rdat);
        @(negedge clk_i);
        periph_req  = 1'b1;
        periph_wen  = wen;
        periph_add  = {24'h1A1000, off};
        periph_data = wdat;
        periph_be   = be;
        periph_id   = cur_id;
        @(negedge clk_i);
        periph_req = 1'b0;
        last_rv    = periph_r_valid;
        last_rid   = periph_r_id;
        rdat       = periph_r_data;
        exp_id     = cur_id;
        cur_id     = cur_id + 10'd37;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] wdat, input logic [3:0] be);
        logic [31:0] dummy;
        reg_acc(1'b0, off, wdat, be, dummy);
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] rdat);
        reg_acc(1'b1, off, 32'h0, 4'hF, rdat);
    endtask

    task automatic setup(input logic [15:0] nb, input logic [15:0] len, input logic [4:0] sh, input logic sm);
        wr(8'h40, 32'h100, 4'hF);
        wr(8'h44, 32'h200, 4'hF);
        wr(8'h48, 32'h300, 4'hF);
        wr(8'h4C, 32'h400, 4'hF);
        wr(8'h50, {16'h0, nb}, 4'hF);
        wr(8'h54, {16'h0, len}, 4'hF);
        wr(8'h58, {27'h0, sh}, 4'hF);
        wr(8'h5C, {31'h0, sm}, 4'hF);
    endtask

    task automatic wait_evt(input string tag, input int budget);
        int n = 0;
        while (!evt_o[0][0] && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        chk(tag, {31'b0, evt_o[0][0]}, 32'd1);
        @(negedge clk_i);
    endtask

    // TCDM memory: grant decided each negedge; read data returned the cycle after the grant.
    initial begin
        logic [3:0]  rsp_v, hold_v;
        logic [31:0] rsp_d [4];
        logic [31:0] hold_add [4];
        logic [31:0] hold_dat;
        rsp_v = '0; hold_v = '0; hold_dat = '0;
        tcdm_gnt = '0; tcdm_r_valid = '0; tcdm_r_data = '0;
        for (int p = 0; p < 4; p++) hs_cnt[p] = 0;
        forever begin
            @(negedge clk_i);
            for (int p = 0; p < 4; p++) begin
                if (hold_v[p] && (!tcdm_req[p] || tcdm_add[p] != hold_add[p] ||
                                  (p == 3 && tcdm_data[3] != hold_dat))) stab_viol++;
                if (tcdm_req[p] && tcdm_be[p] != 4'hF) be_viol++;
                tcdm_r_valid[p] = rsp_v[p];
                tcdm_r_data[p]  = rsp_v[p] ? rsp_d[p] : 32'h0;
                rsp_v[p]        = 1'b0;
                hold_v[p]       = 1'b0;
                tcdm_gnt[p]     = stall ? ($urandom_range(0, 9) != 0) : 1'b1;
                if (tcdm_req[p] && tcdm_gnt[p]) begin
                    hs_cnt[p]++;
                    if (p == 3) begin
                        if (!tcdm_wen[3]) begin
                            mem[tcdm_add[3][10:2]] = tcdm_data[3];
                            wr_cnt++;
                        end
                    end else begin
                        rsp_v[p] = 1'b1;
                        rsp_d[p] = mem[tcdm_add[p][10:2]];
                    end
                end else if (tcdm_req[p]) begin
                    hold_v[p]   = 1'b1;
                    hold_add[p] = tcdm_add[p];
                    if (p == 3) hold_dat = tcdm_data[3];
                end
            end
        end
    end

    initial forever begin
        @(posedge clk_i);
        if (evt_o[0][0]) evt_cnt++;
        if (evt_o[0][1] || evt_o[1][1] || evt_o[0][0] != evt_o[1][0]) evt_bad++;
        if (|tcdm_req) req_cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rdat;
        int evs, rc, wsnap, hs2;
        rst_ni = 1'b1; test_mode_i = 1'b0;
        periph_req = 1'b0; periph_wen = 1'b1; periph_add = '0; periph_data = '0; periph_be = '0; periph_id = '0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        tick(3);
        chk("rst_req",    {28'b0, tcdm_req}, 32'h0);
        chk("rst_wen",    {28'b0, tcdm_wen}, 32'hF);
        chk("rst_be",     {16'b0, tcdm_be}, 32'h0);
        chk("rst_add3",   tcdm_add[3], 32'h0);
        chk("rst_rvalid", {31'b0, periph_r_valid}, 32'h0);
        chk("rst_gnt",    {31'b0, periph_gnt}, 32'h0);
        chk("rst_evt",    {28'b0, evt_o}, 32'h0);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("gnt_up", {31'b0, periph_gnt}, 32'h1);

        wr(8'h40, 32'h1000, 4'hF);
        chk("wr_rvalid", {31'b0, last_rv}, 32'h1);
        rd(8'h40, rdat);
        chk("rb_data",   rdat, 32'h1000);
        chk("rb_rvalid", {31'b0, last_rv}, 32'h1);
        chk("rb_id",     {22'b0, last_rid}, {22'b0, exp_id});
        rd(8'h04, rdat);
        chk("acq_idle", rdat, 32'h0);
        wr(8'h44, 32'hAABBCCDD, 4'hF);
        wr(8'h44, 32'h11111111, 4'b0010);
        rd(8'h44, rdat);
        chk("be_merge", rdat, 32'hAABB11DD);
        wr(8'h60, 32'hFFFFFFFF, 4'hF);
        rd(8'h60, rdat);
        chk("unmapped", rdat, 32'h0);
        wr(8'h58, 32'hFFFFFFFF, 4'hF);
        rd(8'h58, rdat);
        chk("shift_w", rdat, 32'h1F);

        // Simple multiply, LEN=4, SHIFT=0.
        mem[64] = 32'd1; mem[65] = 32'd2; mem[66] = -32'sd3; mem[67] = 32'd4;
        mem[128] = 32'd5; mem[129] = 32'd6; mem[130] = 32'd7; mem[131] = -32'sd8;
        for (int i = 256; i < 260; i++) mem[i] = 32'hDEAD;
        setup(16'd1, 16'd4, 5'd0, 1'b1);
        evs = evt_cnt; hs2 = hs_cnt[2];
        wr(8'h00, 32'h1, 4'hF);
        rd(8'h0C, rdat);
        chk("status_busy", rdat, 32'h1);
        rd(8'h04, rdat);
        chk("acq_busy", rdat, 32'hFFFFFFFF);
        wr(8'h54, 32'd9, 4'hF);
        wait_evt("simple_evt", 400);
        tick(5);
        chk("simple_evt_cnt", evt_cnt - evs, 32'd1);
        chk("simple_d0", mem[256], 32'd5);
        chk("simple_d1", mem[257], 32'd12);
        chk("simple_d2", mem[258], -32'sd21);
        chk("simple_d3", mem[259], -32'sd32);
        chk("simple_no_c", hs_cnt[2] - hs2, 32'd0);
        rd(8'h54, rdat);
        chk("len_locked", rdat, 32'd4);

        // Simple multiply with a 64-bit product and arithmetic shift.
        mem[64] = -32'sd7; mem[65] = 32'h10000;
        mem[128] = 32'd3;  mem[129] = 32'h10000;
        setup(16'd1, 16'd2, 5'd4, 1'b1);
        wr(8'h00, 32'h1, 4'hF);
        wait_evt("shift_evt", 400);
        chk("shift_d0", mem[256], 32'hFFFFFFFE);
        chk("shift_d1", mem[257], 32'h10000000);

        // Accumulate mode, NB_ITER=2, LEN=2, SHIFT=1.
        mem[64] = 32'd2; mem[65] = 32'd3; mem[66] = 32'd4; mem[67] = 32'd5;
        mem[128] = 32'd1; mem[129] = 32'd1; mem[130] = 32'd2; mem[131] = 32'd2;
        mem[192] = 32'd10; mem[193] = 32'd20;
        for (int i = 256; i < 260; i++) mem[i] = 32'hDEAD;
        setup(16'd2, 16'd2, 5'd1, 1'b0);
        wr(8'h00, 32'h1, 4'hF);
        wait_evt("acc_evt", 400);
        chk("acc_d0", mem[256], 32'd12);
        chk("acc_d1", mem[257], 32'd29);
        chk("acc_d2", mem[258], 32'hDEAD);

        // Same job under random grant stalls.
        mem[256] = 32'hDEAD; mem[257] = 32'hDEAD;
        stall = 1'b1;
        wr(8'h00, 32'h1, 4'hF);
        wait_evt("stall_evt", 1500);
        stall = 1'b0;
        chk("stall_d0", mem[256], 32'd12);
        chk("stall_d1", mem[257], 32'd29);
        chk("stall_stable", stab_viol, 32'd0);

        // Zero length goes straight to DONE.
        wr(8'h54, 32'd0, 4'hF);
        rc = req_cyc;
        wr(8'h00, 32'h1, 4'hF);
        wait_evt("len0_evt", 3);
        chk("len0_noreq", req_cyc - rc, 32'd0);

        // Soft clear in the middle of a job.
        setup(16'd1, 16'd4, 5'd0, 1'b1);
        evs = evt_cnt;
        wr(8'h00, 32'h1, 4'hF);
        tick(1);
        wr(8'h14, 32'h0, 4'hF);
        chk("clr_req", {28'b0, tcdm_req}, 32'h0);
        #1 wsnap = wr_cnt;
        rd(8'h0C, rdat);
        chk("clr_status", rdat, 32'h0);
        rd(8'h54, rdat);
        chk("clr_len", rdat, 32'h0);
        tick(20);
        chk("clr_no_wr", wr_cnt - wsnap, 32'd0);
        chk("clr_no_evt", evt_cnt - evs, 32'd0);

        // Reset in the middle of a job.
        setup(16'd1, 16'd4, 5'd0, 1'b1);
        evs = evt_cnt;
        wr(8'h00, 32'h1, 4'hF);
        tick(2);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("mrst_req", {28'b0, tcdm_req}, 32'h0);
        chk("mrst_gnt", {31'b0, periph_gnt}, 32'h0);
        rst_ni = 1'b0;
        #1 wsnap = wr_cnt;
        tick(30);
        chk("mrst_no_wr", wr_cnt - wsnap, 32'd0);
        chk("mrst_no_evt", evt_cnt - evs, 32'd0);
        rd(8'h0C, rdat);
        chk("mrst_status", rdat, 32'h0);

        chk("be_all_f", be_viol, 32'd0);
        chk("evt_shape", evt_bad, 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
